// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem initiator: FSM encoding and the
// packed command record layout used by the command FIFO.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [3:0] IOMEM_READ_STRB = 4'b0000;

  localparam int CMD_W     = 68;
  localparam int WSTRB_LSB = 0;
  localparam int WDATA_LSB = 4;
  localparam int ADDR_LSB  = 36;

  // Record layout is {addr, wdata, wstrb}, matching the offsets above.
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [31:0] addr,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  wstrb);
    return {addr, wdata, wstrb};
  endfunction

endpackage

// File: rtl/iomem_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags; push is refused when full
// even if a pop happens in the same cycle.
module iomem_cmd_fifo
  import iomem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; power-of-2 depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/iomem_initiator.sv
// iomem bus master: queues read/write commands, issues one transfer at a time
// and returns in-order responses with a timeout error flag.
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  localparam int              CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  state_e            state_r;
  state_e            state_nxt_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_pop_s;
  logic [CMD_W-1:0]  head_s;
  logic              xfer_done_s;
  logic              xfer_timeout_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              iomem_valid_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic              rsp_valid_r;
  logic              rsp_error_r;
  logic [31:0]       rsp_rdata_r;

  iomem_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (pack_cmd(cmd_addr, cmd_wdata, cmd_wstrb)),
    .pop       (fifo_pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign cmd_ready   = !fifo_full_s;
  assign busy        = !fifo_empty_s || (state_r != ST_IDLE);
  assign iomem_valid = iomem_valid_r;
  assign iomem_addr  = addr_r;
  assign iomem_wdata = wdata_r;
  assign iomem_wstrb = wstrb_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_error   = rsp_error_r;
  assign rsp_rdata   = rsp_rdata_r;

  // Next-state and transfer-completion decode; ready beats timeout in the final cycle.
  always_comb begin
    state_nxt_s    = state_r;
    fifo_pop_s     = 1'b0;
    xfer_done_s    = 1'b0;
    xfer_timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s  = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (iomem_ready) begin
          xfer_done_s = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (TIMEOUT_EN && (cnt_r == CNT_LIMIT)) begin
          xfer_timeout_s = 1'b1;
          state_nxt_s    = ST_RESP;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Holding registers, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_valid_r <= 1'b0;
      addr_r        <= 32'h0;
      wdata_r       <= 32'h0;
      wstrb_r       <= 4'h0;
      cnt_r         <= {CNT_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_error_r   <= 1'b0;
      rsp_rdata_r   <= 32'h0;
    end else if (fifo_pop_s) begin
      addr_r        <= head_s[ADDR_LSB +: 32];
      wdata_r       <= head_s[WDATA_LSB +: 32];
      wstrb_r       <= head_s[WSTRB_LSB +: 4];
      iomem_valid_r <= 1'b1;
      cnt_r         <= CNT_W'(1);
    end else if (state_r == ST_ISSUE) begin
      if (xfer_done_s || xfer_timeout_s) begin
        iomem_valid_r <= 1'b0;
        rsp_valid_r   <= 1'b1;
        rsp_error_r   <= xfer_timeout_s;
        rsp_rdata_r   <= (xfer_done_s && (wstrb_r == IOMEM_READ_STRB)) ? iomem_rdata : 32'h0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      rsp_valid_r <= 1'b0;
      rsp_error_r <= 1'b0;
      rsp_rdata_r <= 32'h0;
    end
  end

endmodule

// File: tb/tb_iomem_initiator.sv
// Scoreboard bench for iomem_initiator with a programmable-delay iomem responder.
module tb_iomem_initiator;

  localparam int FD = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error, busy;
  logic [31:0] rsp_rdata;
  logic        iomem_valid, iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;

  iomem_initiator #(.FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rsp_seen = 0;
  logic [32:0] sb_q[$];

  // responder model state
  int          resp_delay = 1;
  bit          resp_silent = 1'b0;
  bit          resp_mix = 1'b0;
  logic [31:0] resp_data = 32'h0;
  int          vcnt = 0;
  int          last_len = 0;
  bit          unstable = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                      input logic [32:0] exp, input bit expect_rsp);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = w;
    cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_accept", 64'(cmd_ready), 64'd1);
    if (cmd_ready && expect_rsp) sb_q.push_back(exp);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || rsp_valid) && n < 200) begin
      tick();
      n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  // Responder: pulses ready once after resp_delay valid cycles and records transfer shape.
  initial begin
    iomem_ready = 1'b0;
    iomem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      iomem_ready = 1'b0;
      iomem_rdata = 32'hBAD0_BAD0;
      if (iomem_valid) begin
        if (vcnt == 0) begin
          cap_addr  = iomem_addr;
          cap_wdata = iomem_wdata;
          cap_wstrb = iomem_wstrb;
        end else if (iomem_addr !== cap_addr || iomem_wdata !== cap_wdata ||
                     iomem_wstrb !== cap_wstrb) begin
          unstable = 1'b1;
        end
        if (!resp_silent && vcnt == resp_delay) begin
          iomem_ready = 1'b1;
          iomem_rdata = resp_mix ? {16'hD000, iomem_addr[15:0]} : resp_data;
        end
        vcnt++;
      end else begin
        if (vcnt != 0) last_len = vcnt;
        vcnt = 0;
      end
    end
  end

  // Scoreboard monitor: compares each response on its handshake.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got err=%0d rdata=0x%0h with no command outstanding",
                 rsp_error, rsp_rdata);
      end else begin
        logic [32:0] exp;
        exp = sb_q.pop_front();
        check("rsp_err_rdata", 64'({rsp_error, rsp_rdata}), 64'(exp));
        rsp_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int seen0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 32'h0;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    rsp_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_iomem_valid", 64'(iomem_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_fields", 64'({iomem_addr, iomem_wdata[27:0], iomem_wstrb}), 64'd0);
    check("rst_rsp_fields", 64'({rsp_error, rsp_rdata}), 64'd0);

    // 1: write, ready one cycle after valid; rdata forced to 0
    resp_delay = 1; resp_data = 32'hFFFF_FFFF; unstable = 1'b0;
    send(32'h0300_0000, 32'h0000_00A5, 4'hF, {1'b0, 32'h0}, 1'b1);
    check("t1_latency_n1", 64'(iomem_valid), 64'd0);
    tick();
    check("t1_latency_n2", 64'(iomem_valid), 64'd1);
    wait_idle("t1_idle");
    check("t1_valid_len", 64'(last_len), 64'd2);
    check("t1_addr", 64'(cap_addr), 64'h0300_0000);
    check("t1_wdata", 64'(cap_wdata), 64'h0000_00A5);
    check("t1_wstrb", 64'(cap_wstrb), 64'hF);
    check("t1_stable", 64'(unstable), 64'd0);

    // 2: read returning 0x1234_5678
    resp_delay = 0; resp_data = 32'h1234_5678;
    send(32'h0300_0000, 32'h0, 4'h0, {1'b0, 32'h1234_5678}, 1'b1);
    wait_idle("t2_idle");
    check("t2_valid_len", 64'(last_len), 64'd1);

    // 3: back-pressured responses -> 1 in flight + FD queued, then ordered drain
    rsp_ready = 1'b0; resp_delay = 1; resp_mix = 1'b1;
    seen0 = rsp_seen;
    accepted = 0;
    for (int c = 0; c < 20 && accepted < 6; c++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 32'h0300_0010 + 32'(accepted * 4);
      cmd_wdata = 32'h0;
      cmd_wstrb = 4'h0;
      if (cmd_ready) begin
        sb_q.push_back({1'b0, 32'hD000_0010 + 32'(accepted * 4)});
        accepted++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_accepted", 64'(accepted), 64'd5);
    check("t3_cmd_ready_full", 64'(cmd_ready), 64'd0);
    check("t3_rsp_held", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    wait_idle("t3_idle");
    check("t3_drained", 64'(rsp_seen - seen0), 64'd5);

    // 4: silent responder -> timeout after exactly TO cycles
    resp_mix = 1'b0; resp_silent = 1'b1;
    send(32'h0300_0004, 32'h0, 4'h0, {1'b1, 32'h0}, 1'b1);
    wait_idle("t4_idle");
    check("t4_valid_len", 64'(last_len), 64'd8);

    // 5: ready in the final timeout cycle wins
    resp_silent = 1'b0; resp_delay = 7; resp_data = 32'hCAFE_F00D;
    send(32'h0300_0008, 32'h0, 4'h0, {1'b0, 32'hCAFE_F00D}, 1'b1);
    wait_idle("t5_idle");
    check("t5_valid_len", 64'(last_len), 64'd8);

    // 6: reset during ISSUE with two commands queued
    resp_silent = 1'b1;
    seen0 = rsp_seen;
    send(32'h0300_0020, 32'h1, 4'hF, 33'h0, 1'b0);
    send(32'h0300_0024, 32'h2, 4'hF, 33'h0, 1'b0);
    send(32'h0300_0028, 32'h3, 4'hF, 33'h0, 1'b0);
    tick();
    check("t6_in_issue", 64'(iomem_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_iomem_valid", 64'(iomem_valid), 64'd0);
    check("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (30) tick();
    check("t6_no_stale_rsp", 64'(rsp_seen - seen0), 64'd0);
    check("t6_still_idle", 64'({busy, iomem_valid}), 64'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
